// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a held memory request,
// bus timeout, illegal-opcode trap, FENCE mode and wrapping cycle/retire counters.
module multicycle_control_fsm #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter bit FENCE_HALTS = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Inst,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic [1:0]       AluOp,
   output logic             Branch,
   output logic             MemRead,
   output logic             MemToReg,
   output logic             MemWrite,
   output logic             AluSrc,
   output logic             RegWrite,
   output logic             AUIPC,
   output logic             JAL,
   output logic             JALR,
   output logic             Halt,
   output logic             Illegal,
   output logic             bus_err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALTED = 3'd6;
   localparam logic [2:0] S_TRAP   = 3'd7;

   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_I      = 5'b00100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_FENCE  = 5'b00011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [2:0]        state_q, state_d;
   logic [4:0]        op_q, op_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;
   logic [CNT_W-1:0]  cycle_q, instret_q;
   logic              retire, waiting, active;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      wait_d    = '0;
      retire    = 1'b0;
      waiting   = 1'b0;
      mem_req   = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      AluOp     = 2'b00;
      Branch    = 1'b0;
      MemRead   = 1'b0;
      MemToReg  = 1'b0;
      MemWrite  = 1'b0;
      AluSrc    = 1'b0;
      RegWrite  = 1'b0;
      AUIPC     = 1'b0;
      JAL       = 1'b0;
      JALR      = 1'b0;
      Halt      = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               state_d = S_DECODE;
            end else begin
               waiting = 1'b1;
            end
         end
         S_DECODE: begin
            op_d = Inst;
            case (Inst)
               OP_SYSTEM: state_d = S_HALTED;
               OP_FENCE: begin
                  if (FENCE_HALTS) begin
                     state_d = S_HALTED;
                  end else begin
                     PCWrite = 1'b1;
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
               end
               OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
               OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: state_d = S_EXEC;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_EXEC: begin
            case (op_q)
               OP_R:      begin AluOp = 2'b10; RegWrite = 1'b1; end
               OP_I:      begin AluOp = 2'b10; AluSrc = 1'b1; RegWrite = 1'b1; end
               OP_LUI:    begin AluOp = 2'b11; AluSrc = 1'b1; RegWrite = 1'b1; end
               OP_AUIPC:  begin AluSrc = 1'b1; AUIPC = 1'b1; RegWrite = 1'b1; end
               OP_JAL:    begin AluOp = 2'b11; AluSrc = 1'b1; JAL = 1'b1; RegWrite = 1'b1; end
               OP_JALR:   begin AluSrc = 1'b1; JAL = 1'b1; JALR = 1'b1; RegWrite = 1'b1; end
               OP_BRANCH: begin AluOp = 2'b01; Branch = 1'b1; end
               default:   AluSrc = 1'b1;
            endcase
            if (op_q == OP_LOAD || op_q == OP_STORE) begin
               state_d = S_MEM;
            end else begin
               PCWrite = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            AluSrc   = 1'b1;
            MemRead  = (op_q == OP_LOAD);
            MemWrite = (op_q == OP_STORE);
            if (!mem_ready) begin
               waiting = 1'b1;
            end else if (op_q == OP_STORE) begin
               PCWrite = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         default: Halt = 1'b1;
      endcase
      // A completion arriving on the last allowed wait cycle takes priority over the timeout.
      if (waiting) begin
         wait_d = wait_q + 1'b1;
         if (MEM_TIMEOUT != 0 && wait_q == WAIT_LAST) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
         end
      end
   end

   assign active = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_TRAP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         if (active) cycle_q <= cycle_q + 1'b1;
         if (retire) instret_q <= instret_q + 1'b1;
      end
   end

   assign state       = state_q;
   assign Illegal     = illegal_q;
   assign bus_err     = bus_err_q;
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench: each instruction is expanded into its expected per-cycle state/control trace, which
// also drives mem_ready; a negedge process compares every cycle against that trace.
module tb_multicycle_control_fsm;
   localparam int TO = 4;
   localparam int CW = 4;

   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
   localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALTED = 3'd6, S_TRAP = 3'd7;

   localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LOAD = 5'b00000, OP_STORE = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000, OP_LUI = 5'b01101, OP_AUIPC = 5'b00101;
   localparam logic [4:0] OP_JAL = 5'b11011, OP_JALR = 5'b11001, OP_FENCE = 5'b00011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100, JUNK = 5'b11111;

   // Control word: {mem_req, IRWrite, PCWrite, AluOp[1:0], Branch, MemRead, MemToReg,
   //                MemWrite, AluSrc, RegWrite, AUIPC, JAL, JALR, Halt}
   localparam logic [14:0] M_REQ = 15'h4000, M_IRW = 15'h2000, M_PCW = 15'h1000;
   localparam logic [14:0] A_ALU = 15'h0800, A_BR = 15'h0400, A_PASS = 15'h0C00;
   localparam logic [14:0] M_BR = 15'h0200, M_MRD = 15'h0100, M_M2R = 15'h0080, M_MWR = 15'h0040;
   localparam logic [14:0] M_SRC = 15'h0020, M_RW = 15'h0010, M_AUI = 15'h0008, M_JAL = 15'h0004;
   localparam logic [14:0] M_JALR = 15'h0002, M_HALT = 15'h0001;

   logic clk = 1'b0;
   logic rst, mem_ready;
   logic [4:0] Inst;
   logic mem_req, IRWrite, PCWrite, Branch, MemRead, MemToReg, MemWrite, AluSrc, RegWrite;
   logic AUIPC, JAL, JALR, Halt, Illegal, bus_err;
   logic [1:0] AluOp;
   logic [2:0] state;
   logic [CW-1:0] cycle_cnt, instret_cnt;

   logic rst_b, mem_ready_b;
   logic [4:0] Inst_b;
   logic req_b, irw_b, pcw_b, br_b, mrd_b, m2r_b, mwr_b, src_b, rw_b, aui_b, jal_b, jalr_b;
   logic halt_b, ill_b, berr_b;
   logic [1:0] aop_b;
   logic [2:0] state_b;
   logic [31:0] cycle_b, instret_b;

   multicycle_control_fsm #(.CNT_W(CW), .MEM_TIMEOUT(TO), .FENCE_HALTS(1'b0)) dut (
      .clk(clk), .rst(rst), .Inst(Inst), .mem_ready(mem_ready), .mem_req(mem_req),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .AluOp(AluOp), .Branch(Branch), .MemRead(MemRead),
      .MemToReg(MemToReg), .MemWrite(MemWrite), .AluSrc(AluSrc), .RegWrite(RegWrite),
      .AUIPC(AUIPC), .JAL(JAL), .JALR(JALR), .Halt(Halt), .Illegal(Illegal), .bus_err(bus_err),
      .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt));

   multicycle_control_fsm dut_b (
      .clk(clk), .rst(rst_b), .Inst(Inst_b), .mem_ready(mem_ready_b), .mem_req(req_b),
      .IRWrite(irw_b), .PCWrite(pcw_b), .AluOp(aop_b), .Branch(br_b), .MemRead(mrd_b),
      .MemToReg(m2r_b), .MemWrite(mwr_b), .AluSrc(src_b), .RegWrite(rw_b),
      .AUIPC(aui_b), .JAL(jal_b), .JALR(jalr_b), .Halt(halt_b), .Illegal(ill_b), .bus_err(berr_b),
      .state(state_b), .cycle_cnt(cycle_b), .instret_cnt(instret_b));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   logic [2:0] e_state = S_IDLE;
   logic [14:0] e_ctl = '0;
   logic e_ill = 1'b0, e_berr = 1'b0, chk_en = 1'b0;
   logic [CW-1:0] e_cyc = '0, e_ret = '0;
   logic [2:0] term_st;
   logic [14:0] ctl_vec;

   assign ctl_vec = {mem_req, IRWrite, PCWrite, AluOp, Branch, MemRead, MemToReg,
                     MemWrite, AluSrc, RegWrite, AUIPC, JAL, JALR, Halt};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("state", 32'(state), 32'(e_state));
         chk("controls", 32'(ctl_vec), 32'(e_ctl));
         chk("Illegal", 32'(Illegal), 32'(e_ill));
         chk("bus_err", 32'(bus_err), 32'(e_berr));
         chk("cycle_cnt", 32'(cycle_cnt), 32'(e_cyc));
         chk("instret_cnt", 32'(instret_cnt), 32'(e_ret));
      end
   end

   function automatic logic [14:0] exec_ctl(input logic [4:0] op);
      case (op)
         OP_R:      return A_ALU | M_RW | M_PCW;
         OP_I:      return A_ALU | M_SRC | M_RW | M_PCW;
         OP_LUI:    return A_PASS | M_SRC | M_RW | M_PCW;
         OP_AUIPC:  return M_SRC | M_AUI | M_RW | M_PCW;
         OP_JAL:    return A_PASS | M_SRC | M_JAL | M_RW | M_PCW;
         OP_JALR:   return M_SRC | M_JAL | M_JALR | M_RW | M_PCW;
         OP_BRANCH: return A_BR | M_BR | M_PCW;
         default:   return M_SRC;
      endcase
   endfunction

   function automatic bit is_known(input logic [4:0] op);
      return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
                        OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM};
   endfunction

   // Called at posedge+1; leaves the bench at posedge+1 of the following cycle.
   task automatic step(input logic [2:0] st, input logic [14:0] ctl, input logic rdy,
                       input logic [4:0] ins, input logic ret);
      mem_ready = rdy;
      Inst = ins;
      e_state = st;
      e_ctl = ctl;
      chk_en = 1'b1;
      @(negedge clk);
      #1;
      if (st inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB}) e_cyc++;
      if (ret) e_ret++;
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [4:0] op, input int fw, input int mw);
      logic [14:0] mc;
      term_st = S_IDLE;
      for (int i = 0; i < fw && i < TO; i++) step(S_FETCH, M_REQ | M_MRD, 1'b0, JUNK, 1'b0);
      if (fw >= TO) begin
         e_berr = 1'b1;
         term_st = S_TRAP;
         return;
      end
      step(S_FETCH, M_REQ | M_MRD | M_IRW, 1'b1, JUNK, 1'b0);
      if (!is_known(op)) begin
         step(S_DECODE, '0, 1'b0, op, 1'b0);
         e_ill = 1'b1;
         term_st = S_TRAP;
         return;
      end
      if (op == OP_SYSTEM) begin
         step(S_DECODE, '0, 1'b0, op, 1'b0);
         term_st = S_HALTED;
         return;
      end
      if (op == OP_FENCE) begin
         step(S_DECODE, M_PCW, 1'b1, op, 1'b1);
         return;
      end
      step(S_DECODE, '0, 1'b1, op, 1'b0);
      step(S_EXEC, exec_ctl(op), 1'b1, JUNK, !(op == OP_LOAD || op == OP_STORE));
      if (!(op == OP_LOAD || op == OP_STORE)) return;
      mc = M_REQ | M_SRC | ((op == OP_LOAD) ? M_MRD : M_MWR);
      for (int i = 0; i < mw && i < TO; i++) step(S_MEM, mc, 1'b0, JUNK, 1'b0);
      if (mw >= TO) begin
         e_berr = 1'b1;
         term_st = S_TRAP;
         return;
      end
      if (op == OP_STORE) begin
         step(S_MEM, mc | M_PCW, 1'b1, JUNK, 1'b1);
      end else begin
         step(S_MEM, mc, 1'b1, JUNK, 1'b0);
         step(S_WB, M_M2R | M_RW | M_PCW, 1'b1, JUNK, 1'b1);
      end
   endtask

   task automatic park(input int n);
      for (int i = 0; i < n; i++) step(term_st, M_HALT, 1'($urandom_range(0, 1)), JUNK, 1'b0);
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst = 1'b0;
      mem_ready = 1'b0;
      Inst = '0;
      @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_controls", 32'(ctl_vec), 0);
      chk("rst_flags", {30'd0, Illegal, bus_err}, 0);
      chk("rst_counters", {24'd0, cycle_cnt, instret_cnt}, 0);
      rst = 1'b1;
      e_cyc = '0;
      e_ret = '0;
      e_ill = 1'b0;
      e_berr = 1'b0;
      step(S_IDLE, '0, 1'b0, JUNK, 1'b0);
   endtask

   logic [4:0] alu_ops [6];
   logic [4:0] bad_ops [2];

   initial begin
      alu_ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_BRANCH};
      bad_ops = '{5'b11111, 5'b00001};
      rst = 1'b0;
      rst_b = 1'b0;
      mem_ready = 1'b0;
      mem_ready_b = 1'b0;
      Inst = '0;
      Inst_b = '0;

      do_reset();
      instr(OP_R, 0, 0);
      chk("add_cycles", 32'(cycle_cnt), 3);
      chk("add_instret", 32'(instret_cnt), 1);
      instr(OP_I, 1, 0);
      instr(OP_LUI, 0, 0);
      instr(OP_AUIPC, 2, 0);
      instr(OP_JAL, 0, 0);
      instr(OP_JALR, 0, 0);

      do_reset();
      instr(OP_LOAD, 0, 2);
      chk("load_cycles", 32'(cycle_cnt), 7);
      chk("load_instret", 32'(instret_cnt), 1);

      do_reset();
      instr(OP_STORE, 0, 0);
      instr(OP_BRANCH, 0, 0);
      chk("st_br_instret", 32'(instret_cnt), 2);
      chk("st_br_cycles", 32'(cycle_cnt), 7);

      do_reset();
      instr(OP_FENCE, 0, 0);
      chk("fence_instret", 32'(instret_cnt), 1);
      chk("fence_next_fetch", 32'(state), 32'(S_FETCH));
      instr(OP_SYSTEM, 0, 0);
      park(3);
      chk("sys_halt", 32'(Halt), 1);
      chk("sys_cycles", 32'(cycle_cnt), 4);

      for (int k = 0; k < 2; k++) begin
         do_reset();
         instr(bad_ops[k], 0, 0);
         park(3);
         chk("illegal_flag", 32'(Illegal), 1);
         chk("illegal_state", 32'(state), 32'(S_TRAP));
         chk("illegal_instret", 32'(instret_cnt), 0);
      end

      do_reset();
      instr(OP_R, 3, 0);
      instr(OP_LOAD, 2, 3);
      chk("late_ready_no_err", 32'(bus_err), 0);
      instr(OP_R, 4, 0);
      park(3);
      chk("timeout_bus_err", 32'(bus_err), 1);
      chk("timeout_state", 32'(state), 32'(S_TRAP));
      chk("timeout_instret", 32'(instret_cnt), 2);
      chk("timeout_cycles", 32'(cycle_cnt), 4);

      do_reset();
      for (int i = 0; i < 18; i++) instr(alu_ops[i % 6], i % 3, 0);
      chk("wrap_instret", 32'(instret_cnt), 2);

      do_reset();
      step(S_FETCH, M_REQ | M_MRD | M_IRW, 1'b1, JUNK, 1'b0);
      step(S_DECODE, '0, 1'b0, OP_LOAD, 1'b0);
      step(S_EXEC, M_SRC, 1'b0, JUNK, 1'b0);
      step(S_MEM, M_REQ | M_SRC | M_MRD, 1'b0, JUNK, 1'b0);
      chk_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("midmem_state", 32'(state), 32'(S_IDLE));
      chk("midmem_controls", 32'(ctl_vec), 0);
      chk("midmem_counters", {24'd0, cycle_cnt, instret_cnt}, 0);

      @(posedge clk);
      #1;
      rst_b = 1'b1;
      mem_ready_b = 1'b1;
      @(posedge clk);
      #1;
      chk("b_fetch", 32'(state_b), 32'(S_FETCH));
      @(posedge clk);
      #1;
      Inst_b = OP_FENCE;
      chk("b_decode", 32'(state_b), 32'(S_DECODE));
      @(posedge clk);
      #1;
      Inst_b = OP_R;
      chk("b_fence_halted", 32'(state_b), 32'(S_HALTED));
      chk("b_halt", 32'(halt_b), 1);
      chk("b_instret", instret_b, 0);
      chk("b_cycles", cycle_b, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequential successor to the single-cycle opcode decoder. It sequences each RV32I instruction through fetch, decode, execute, memory and writeback states, and drives the existing datapath control signals per state. It handshakes with a variable-latency memory and adds a bus timeout, illegal-opcode trapping, a configurable FENCE mode and retirement/cycle counters. It sits between IR/PC/memory and the datapath in the multi-cycle core.

Parameters:
CNT_W, 32, width of cycle_cnt and instret_cnt; both wrap modulo 2^CNT_W.
MEM_TIMEOUT, 16, number of consecutive wait cycles without mem_ready before a bus error; 0 disables the timeout.
FENCE_HALTS, 1, 1: FENCE halts the core; 0: FENCE retires as a NOP.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
Inst  in  5  opcode bits [6:2] from IR; valid from DECODE onward
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
IRWrite  out  1  load IR from memory read data
PCWrite  out  1  update PC (PC+4, branch target or jump target per datapath)
AluOp  out  2  ALU operation class
Branch, MemRead, MemToReg, MemWrite, AluSrc, RegWrite, AUIPC, JAL, JALR  out  1 each  datapath controls
Halt  out  1  core stopped
Illegal  out  1  sticky, set on an undefined opcode
bus_err  out  1  sticky, set on a memory timeout
state  out  3  current state encoding, for debug
cycle_cnt  out  CNT_W  count of active cycles
instret_cnt  out  CNT_W  count of retired instructions

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, TRAP=7.
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; counters 0; Illegal=0; bus_err=0; wait counter 0.
- IDLE: all controls 0. Always moves to FETCH on the next cycle.
- FETCH: mem_req=1, MemRead=1. When mem_ready=1: IRWrite=1 in that same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle): latch Inst into op_q. All controls 0. Next state:
  - Undefined opcode → TRAP, set Illegal.
  - SYSTEM(11100) → HALTED.
  - FENCE(00011) with FENCE_HALTS=1 → HALTED.
  - FENCE(00011) with FENCE_HALTS=0 → PCWrite=1, retire, → FETCH.
  - All other opcodes → EXEC.
- Opcodes: R=01100, I=00100, LOAD=00000, STORE=01000, BRANCH=11000, LUI=01101, AUIPC=00101, JAL=11011, JALR=11001.
- EXEC: drive per op_q.
  - R: AluOp=10, AluSrc=0, RegWrite=1.
  - I: AluOp=10, AluSrc=1, RegWrite=1.
  - LUI: AluOp=11, AluSrc=1, RegWrite=1.
  - AUIPC: AluOp=00, AluSrc=1, AUIPC=1, RegWrite=1.
  - JAL: AluOp=11, AluSrc=1, JAL=1, RegWrite=1.
  - JALR: AluOp=00, AluSrc=1, JAL=1, JALR=1, RegWrite=1.
  - BRANCH: AluOp=01, AluSrc=0, Branch=1.
  - LOAD/STORE: AluOp=00, AluSrc=1.
  - For every op except LOAD/STORE: PCWrite=1, retire, → FETCH. LOAD/STORE → MEM.
- MEM: mem_req=1, AluOp=00, AluSrc=1, plus MemRead=1 (LOAD) or MemWrite=1 (STORE).
  - On mem_ready, STORE: PCWrite=1, retire, → FETCH.
  - On mem_ready, LOAD: → WB.
  - Controls are held stable while waiting.
- WB: MemToReg=1, RegWrite=1, PCWrite=1, retire, → FETCH.
- HALTED: Halt=1, all other controls 0. The only exit is reset.
- TRAP: Halt=1, all other controls 0, Illegal/bus_err held. The only exit is reset.
- Timeout:
  - The wait counter increments on each FETCH/MEM cycle with mem_ready=0, and clears on mem_ready or on state exit.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT-1 with mem_ready=0 → TRAP and set bus_err; mem_req drops the next cycle.
  - If mem_ready arrives in that same cycle, completion wins and no error is raised.
- Counters:
  - cycle_cnt increments every cycle while state is not IDLE, HALTED or TRAP.
  - instret_cnt increments on the retire cycle.
  - Both wrap from all-ones to 0.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - ALU/branch/jump: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Reset asserted mid-operation: state and outputs clear immediately, with no retire.

Test Plan:
- R-type ADD, mem_ready always 1 → FETCH, DECODE, EXEC; RegWrite=1 and AluOp=10 in EXEC; instret_cnt=1 and cycle_cnt=3 after retire.
- LOAD, mem_ready delayed by 2 cycles in MEM → MemRead held for 3 cycles; WB asserts MemToReg=1 and RegWrite=1; total 7 cycles.
- STORE followed by BRANCH → MemWrite only in MEM; Branch=1 and AluOp=01 in EXEC; instret_cnt=2.
- SYSTEM (11100) → Halt=1 from the cycle after DECODE; counters freeze. FENCE with FENCE_HALTS=0 → retires in DECODE and the next fetch starts.
- Opcode 11111 → TRAP, Illegal=1, Halt=1; instret_cnt unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → TRAP after the 4th wait cycle, bus_err=1. Then assert rst mid-MEM on a later run → all outputs 0 at once and state returns to IDLE.
